obstacle_field_engine: RTL and testbench

//  Game-field engine for the runner game: owns the 16-cell obstacle lane, dinosaur jump timing,

---
 rtl/obstacle_field_engine.sv | 148 ++++++++++++++
 tb/tb_obstacle_field_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/obstacle_field_engine.sv
// obstacle_field_engine
//   Game-field engine for the runner game. Owns the obstacle lane, the
//   dinosaur jump timer, collision detection and the run score.
//
//   Ports
//     CLK               system clock
//     RST               synchronous active-high reset
//     shift_enable      1-cycle scroll tick
//     jump_trigger      1-cycle jump request
//     start_game        1-cycle pulse: clear field and begin a run
//     force_game_over   1-cycle pulse: abort the current run
//     rand_val          free-running LFSR value, sampled on scroll ticks
//     game_over         high while in OVER
//     dino_on_ground    high while the dino is in the lower row
//     score             scroll ticks survived in the current run
//     obstacle_map_flat cell i at [2i+1:2i]; 00 = empty, else obstacle type
module obstacle_field_engine #(
    parameter int MAP_LEN      = 16,
    parameter int JUMP_TICKS   = 3,
    parameter int MIN_GAP      = 3,
    parameter int SPAWN_THRESH = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 shift_enable,
    input  logic                 jump_trigger,
    input  logic                 start_game,
    input  logic                 force_game_over,
    input  logic [15:0]          rand_val,
    output logic                 game_over,
    output logic                 dino_on_ground,
    output logic [31:0]          score,
    output logic [2*MAP_LEN-1:0] obstacle_map_flat
);

    localparam int AIR_W = $clog2(JUMP_TICKS + 1);
    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic [AIR_W-1:0] AIR_LOAD = AIR_W'(JUMP_TICKS);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);
    localparam logic [7:0]       THRESH   = 8'(SPAWN_THRESH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [MAP_LEN-1:0][1:0]    map_q, map_d;
    logic [31:0]                score_q, score_d;
    logic [AIR_W-1:0]           air_q, air_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic                       over_q, over_d;
    logic                       ground_q, ground_d;
    logic                       spawn;

    // Upper LFSR bits carry no meaning for the lane.
    logic unused_rand;
    assign unused_rand = ^rand_val[15:10];

    function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] g);
        return (g >= GAP_MAX) ? GAP_MAX : g + 1'b1;
    endfunction

    function automatic logic [31:0] score_sat_inc(input logic [31:0] s);
        return (s == 32'hFFFF_FFFF) ? s : s + 32'd1;
    endfunction

    assign spawn = (gap_q >= GAP_MAX) && (rand_val[7:0] < THRESH);

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        score_d = score_q;
        air_d   = air_q;
        gap_d   = gap_q;

        if (start_game) begin
            state_d = S_RUN;
            map_d   = '0;
            score_d = '0;
            air_d   = '0;
            gap_d   = GAP_MAX;
        end else if (state_q == S_RUN) begin
            if (force_game_over) begin
                state_d = S_OVER;
            end else begin
                // A jump from the ground reloads the timer and suppresses the
                // tick's decrement; a jump while airborne is simply ignored.
                if (jump_trigger && (air_q == '0)) begin
                    air_d = AIR_LOAD;
                end else if (shift_enable && (air_q != '0)) begin
                    air_d = air_q - 1'b1;
                end

                if (shift_enable) begin
                    for (int i = 0; i < MAP_LEN - 1; i++) begin
                        map_d[i] = map_q[i+1];
                    end
                    if (spawn) begin
                        map_d[MAP_LEN-1] = (rand_val[9:8] == 2'b00) ? 2'b01 : rand_val[9:8];
                        gap_d            = '0;
                    end else begin
                        map_d[MAP_LEN-1] = 2'b00;
                        gap_d            = gap_sat_inc(gap_q);
                    end

                    // Collision uses the post-tick cell 0 and post-tick height,
                    // so landing onto an obstacle is caught on the landing tick.
                    if ((map_q[1] != 2'b00) && (air_d == '0)) begin
                        state_d = S_OVER;
                    end else begin
                        score_d = score_sat_inc(score_q);
                    end
                end
            end
        end

        over_d   = (state_d == S_OVER);
        ground_d = (air_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            map_q    <= '0;
            score_q  <= '0;
            air_q    <= '0;
            gap_q    <= GAP_MAX;
            over_q   <= 1'b0;
            ground_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            map_q    <= map_d;
            score_q  <= score_d;
            air_q    <= air_d;
            gap_q    <= gap_d;
            over_q   <= over_d;
            ground_q <= ground_d;
        end
    end

    assign game_over         = over_q;
    assign dino_on_ground    = ground_q;
    assign score             = score_q;
    assign obstacle_map_flat = map_q;

endmodule

// File: tb/tb_obstacle_field_engine.sv
module tb_obstacle_field_engine;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        shift_enable = 1'b0;
    logic        jump_trigger = 1'b0;
    logic        start_game = 1'b0;
    logic        force_game_over = 1'b0;
    logic [15:0] rand_val = 16'h0000;
    logic        game_over;
    logic        dino_on_ground;
    logic [31:0] score;
    logic [31:0] obstacle_map_flat;

    int n_vec = 0;
    int n_err = 0;

    obstacle_field_engine dut (
        .CLK              (CLK),
        .RST              (RST),
        .shift_enable     (shift_enable),
        .jump_trigger     (jump_trigger),
        .start_game       (start_game),
        .force_game_over  (force_game_over),
        .rand_val         (rand_val),
        .game_over        (game_over),
        .dino_on_ground   (dino_on_ground),
        .score            (score),
        .obstacle_map_flat(obstacle_map_flat)
    );

    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic sh, input logic jp, input logic st,
                        input logic fo, input logic rs, input logic [15:0] rv);
        shift_enable    = sh;
        jump_trigger    = jp;
        start_game      = st;
        force_game_over = fo;
        RST             = rs;
        rand_val        = rv;
        @(posedge CLK);
        #1;
        shift_enable    = 1'b0;
        jump_trigger    = 1'b0;
        start_game      = 1'b0;
        force_game_over = 1'b0;
        RST             = 1'b0;
    endtask

    task automatic ticks(input int n, input logic [15:0] rv);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rv);
    endtask

    task automatic start_run();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk_eq("rst_go",     game_over, 0);
        chk_eq("rst_ground", dino_on_ground, 1);
        chk_eq("rst_score",  score, 0);
        chk_eq("rst_map",    obstacle_map_flat, 0);

        // Idle ignores ticks
        ticks(2, 16'h0000);
        chk_eq("idle_score", score, 0);
        chk_eq("idle_map",   obstacle_map_flat, 0);

        // 1: no spawns
        start_run();
        ticks(5, 16'h00FF);
        chk_eq("t1_map",   obstacle_map_flat, 0);
        chk_eq("t1_score", score, 5);
        chk_eq("t1_go",    game_over, 0);

        // 2: spawn every 4th tick, grounded collision on tick 16
        start_run();
        ticks(1, 16'h0000);
        chk_eq("t2_first", obstacle_map_flat, 32'h4000_0000);
        ticks(14, 16'h0000);
        chk_eq("t2_map15",   obstacle_map_flat, 32'h0404_0404);
        chk_eq("t2_score15", score, 15);
        chk_eq("t2_go15",    game_over, 0);
        ticks(1, 16'h0000);
        chk_eq("t2_go16",    game_over, 1);
        chk_eq("t2_score16", score, 15);
        chk_eq("t2_map16",   obstacle_map_flat, 32'h0101_0101);
        ticks(2, 16'h0000);
        chk_eq("t2_over_score", score, 15);
        chk_eq("t2_over_map",   obstacle_map_flat, 32'h0101_0101);

        // 3: jump with tick 15 clears the obstacle, lands on tick 18
        start_run();
        ticks(14, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_eq("t3_air15", dino_on_ground, 0);
        ticks(1, 16'h0000);
        chk_eq("t3_go16",  game_over, 0);
        chk_eq("t3_air16", dino_on_ground, 0);
        ticks(1, 16'h0000);
        chk_eq("t3_air17", dino_on_ground, 0);
        ticks(1, 16'h0000);
        chk_eq("t3_land18",  dino_on_ground, 1);
        chk_eq("t3_go18",    game_over, 0);
        chk_eq("t3_score18", score, 18);

        // 4: jump without tick; jump while airborne ignored
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_eq("t4_jump_notick", dino_on_ground, 0);
        chk_eq("t4_score_hold",  score, 18);
        ticks(1, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        ticks(1, 16'h0000);
        chk_eq("t4_air20", dino_on_ground, 0);
        chk_eq("t4_go20",  game_over, 0);
        ticks(1, 16'h0000);
        chk_eq("t4_land21",  dino_on_ground, 1);
        chk_eq("t4_go21",    game_over, 0);
        chk_eq("t4_score21", score, 21);

        // 5: force_game_over beats a coincident tick; OVER freezes everything
        start_run();
        ticks(7, 16'h0000);
        chk_eq("t5_map7", obstacle_map_flat, 32'h0404_0000);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk_eq("t5_go",    game_over, 1);
        chk_eq("t5_score", score, 7);
        chk_eq("t5_map",   obstacle_map_flat, 32'h0404_0000);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_eq("t5_frz_score",  score, 7);
        chk_eq("t5_frz_map",    obstacle_map_flat, 32'h0404_0000);
        chk_eq("t5_frz_ground", dino_on_ground, 1);
        start_run();
        chk_eq("t5_rst_go",    game_over, 0);
        chk_eq("t5_rst_score", score, 0);
        chk_eq("t5_rst_map",   obstacle_map_flat, 0);

        // Threshold boundary and obstacle types
        ticks(1, 16'h0040);
        chk_eq("thr_64_nospawn", obstacle_map_flat, 0);
        ticks(1, 16'h023F);
        chk_eq("thr_63_type2", obstacle_map_flat, 32'h8000_0000);
        ticks(1, 16'h0300);
        chk_eq("gap_block", obstacle_map_flat, 32'h2000_0000);
        ticks(3, 16'h0300);
        chk_eq("type3", obstacle_map_flat[31:30], 2'b11);

        // start_game mid-run restarts
        start_run();
        chk_eq("restart_score", score, 0);
        chk_eq("restart_map",   obstacle_map_flat, 0);

        // 6: RST mid-run while airborne
        ticks(9, 16'h00FF);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF);
        chk_eq("t6_score9", score, 9);
        chk_eq("t6_air",    dino_on_ground, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk_eq("t6_rst_score",  score, 0);
        chk_eq("t6_rst_ground", dino_on_ground, 1);
        chk_eq("t6_rst_go",     game_over, 0);
        chk_eq("t6_rst_map",    obstacle_map_flat, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
        ticks(2, 16'h0000);
        chk_eq("t6_rststart_score", score, 0);
        chk_eq("t6_rststart_map",   obstacle_map_flat, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk_eq("t6_idle_force", game_over, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
